// File: rtl/sad_datapath.sv
`default_nettype none
// ============================================================================
// Module      : sad_datapath
// Description : SAD engine datapath. Index counter, |A-B| accumulator and
//               result register driven by the SAD controller strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module sad_datapath #(
    parameter int DATA_W = 8,
    parameter int N      = 256,
    parameter int ADDR_W = 8,
    parameter int SUM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              AB_rd,
    input  logic              i_inc,
    input  logic              i_clr,
    input  logic              sum_ld,
    input  logic              sum_clr,
    input  logic              sad_reg_ld,
    input  logic [DATA_W-1:0] A_data,
    input  logic [DATA_W-1:0] B_data,
    output logic [ADDR_W-1:0] AB_addr,
    output logic              A_rd,
    output logic              B_rd,
    output logic              i_lt_256,
    output logic [SUM_W-1:0]  sad,
    output logic              sad_valid
);

    // One extra index bit so the counter can hold N itself.
    localparam logic [ADDR_W:0] c_n = (ADDR_W+1)'(N);

    logic [ADDR_W:0]   r_i;
    logic [SUM_W-1:0]  r_sum;
    logic [SUM_W-1:0]  r_sad;
    logic              r_sad_valid;
    logic [DATA_W-1:0] w_diff;
    logic [SUM_W-1:0]  w_diff_ext;

    assign w_diff     = (A_data >= B_data) ? (A_data - B_data) : (B_data - A_data);
    assign w_diff_ext = SUM_W'(w_diff);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i <= '0;
        end else if (i_clr) begin
            r_i <= '0;
        end else if (i_inc && (r_i != c_n)) begin
            r_i <= r_i + 1'b1;
        end
    end

    // Accumulation wraps modulo 2**SUM_W by construction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
        end else if (sum_clr) begin
            r_sum <= '0;
        end else if (sum_ld) begin
            r_sum <= r_sum + w_diff_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sad       <= '0;
            r_sad_valid <= 1'b0;
        end else begin
            r_sad_valid <= sad_reg_ld;
            if (sad_reg_ld) begin
                r_sad <= r_sum;
            end
        end
    end

    assign AB_addr   = r_i[ADDR_W-1:0];
    assign A_rd      = AB_rd;
    assign B_rd      = AB_rd;
    assign i_lt_256  = (r_i < c_n);
    assign sad       = r_sad;
    assign sad_valid = r_sad_valid;

endmodule
`default_nettype wire

// File: tb/tb_sad_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_sad_datapath
// Description : Directed self-checking bench for sad_datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sad_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        AB_rd = 1'b0, i_inc = 1'b0, i_clr = 1'b0;
    logic        sum_ld = 1'b0, sum_clr = 1'b0, sad_reg_ld = 1'b0;
    logic [7:0]  A_data, B_data;
    logic [7:0]  AB_addr;
    logic        A_rd, B_rd, i_lt_256, sad_valid;
    logic [15:0] sad;

    logic        sum_ld8 = 1'b0, sum_clr8 = 1'b0, sad_ld8 = 1'b0;
    logic [7:0]  a8 = 8'h00, b8 = 8'h00;
    logic [7:0]  addr8, sad8;
    logic        a_rd8, b_rd8, lt8, valid8;

    logic [7:0]  a_mem [256];
    logic [7:0]  b_mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign A_data = a_mem[AB_addr];
    assign B_data = b_mem[AB_addr];

    sad_datapath #(.DATA_W(8), .N(256), .ADDR_W(8), .SUM_W(16)) dut (
        .clk(clk), .rst(rst), .AB_rd(AB_rd), .i_inc(i_inc), .i_clr(i_clr),
        .sum_ld(sum_ld), .sum_clr(sum_clr), .sad_reg_ld(sad_reg_ld),
        .A_data(A_data), .B_data(B_data), .AB_addr(AB_addr), .A_rd(A_rd),
        .B_rd(B_rd), .i_lt_256(i_lt_256), .sad(sad), .sad_valid(sad_valid)
    );

    sad_datapath #(.DATA_W(8), .N(256), .ADDR_W(8), .SUM_W(8)) dut8 (
        .clk(clk), .rst(rst), .AB_rd(1'b0), .i_inc(1'b0), .i_clr(1'b0),
        .sum_ld(sum_ld8), .sum_clr(sum_clr8), .sad_reg_ld(sad_ld8),
        .A_data(a8), .B_data(b8), .AB_addr(addr8), .A_rd(a_rd8),
        .B_rd(b_rd8), .i_lt_256(lt8), .sad(sad8), .sad_valid(valid8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        AB_rd = 0; i_inc = 0; i_clr = 0; sum_ld = 0; sum_clr = 0; sad_reg_ld = 0;
    endtask

    task automatic clear();
        idle();
        i_clr = 1; sum_clr = 1;
        step();
        idle();
    endtask

    task automatic accumulate(input int n);
        AB_rd = 1; i_inc = 1; sum_ld = 1;
        for (int k = 0; k < n; k++) step();
        idle();
    endtask

    // Clear, N accumulate cycles, load result; check sad and the valid pulse.
    task automatic run_block(input logic [15:0] exp, input string name);
        clear();
        AB_rd = 1; i_inc = 1; sum_ld = 1;
        for (int k = 0; k < 256; k++) begin
            step();
            if (k == 254) begin
                n_checks++;
                if (i_lt_256 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_lt_at255 got %b want 1", name, i_lt_256);
                end
            end
        end
        idle();
        n_checks++;
        if (i_lt_256 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_lt_at256 got %b want 0", name, i_lt_256);
        end
        sad_reg_ld = 1;
        step();
        sad_reg_ld = 0;
        n_checks++;
        if (sad !== exp || sad_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_sad got %0d/%b want %0d/1", name, sad, sad_valid, exp);
        end
        step();
        n_checks++;
        if (sad_valid !== 1'b0 || sad !== exp) begin
            n_fail++;
            $display("FAIL %s_hold got %0d/%b want %0d/0", name, sad, sad_valid, exp);
        end
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < 256; k++) begin
            a_mem[k] = 8'(k);
            b_mem[k] = 8'(255 - k);
        end
    endtask

    task automatic fill_const(input logic [7:0] a, input logic [7:0] b);
        for (int k = 0; k < 256; k++) begin
            a_mem[k] = a;
            b_mem[k] = b;
        end
    endtask

    task automatic test_reset();
        rst = 1;
        AB_rd = 1'($urandom); i_inc = 1'($urandom); i_clr = 1'($urandom);
        sum_ld = 1'($urandom); sum_clr = 1'($urandom); sad_reg_ld = 1'($urandom);
        step();
        n_checks++;
        if (AB_addr !== 8'd0 || i_lt_256 !== 1'b1 || sad !== 16'd0 || sad_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got addr=%0d lt=%b sad=%0d v=%b want 0/1/0/0",
                     AB_addr, i_lt_256, sad, sad_valid);
        end
        rst = 0;
        idle();
        sad_reg_ld = 1;
        step();
        sad_reg_ld = 0;
        n_checks++;
        if (sad !== 16'd0 || sad_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_sum got %0d/%b want 0/1", sad, sad_valid);
        end
    endtask

    task automatic test_full_block();
        fill_ramp();
        run_block(16'd32768, "ramp");
        n_checks++;
        if (A_rd !== 1'b0 || B_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_idle got %b%b want 00", A_rd, B_rd);
        end
        AB_rd = 1;
        #1;
        n_checks++;
        if (A_rd !== 1'b1 || B_rd !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_pass got %b%b want 11", A_rd, B_rd);
        end
        AB_rd = 0;
    endtask

    task automatic test_extremes();
        fill_const(8'h5A, 8'h5A);
        run_block(16'd0, "equal");
        fill_const(8'hFF, 8'h00);
        run_block(16'd65280, "max");
        fill_const(8'h00, 8'hFF);
        run_block(16'd65280, "max_rev");
    endtask

    task automatic test_priority();
        fill_const(8'h00, 8'h00);
        a_mem[0] = 10; a_mem[1] = 20; a_mem[2] = 10; a_mem[3] = 20;
        a_mem[4] = 10; a_mem[5] = 20; a_mem[6] = 10; a_mem[7] = 5;
        clear();
        accumulate(7);
        n_checks++;
        if (AB_addr !== 8'd7) begin
            n_fail++;
            $display("FAIL prio_i7 got %0d want 7", AB_addr);
        end
        // Load coincident with accumulate: result must be the pre-update sum.
        sad_reg_ld = 1; sum_ld = 1;
        step();
        idle();
        n_checks++;
        if (sad !== 16'd100) begin
            n_fail++;
            $display("FAIL prio_ld_old got %0d want 100", sad);
        end
        sad_reg_ld = 1;
        step();
        idle();
        n_checks++;
        if (sad !== 16'd105) begin
            n_fail++;
            $display("FAIL prio_ld_new got %0d want 105", sad);
        end
        i_clr = 1; i_inc = 1; sum_clr = 1; sum_ld = 1;
        step();
        idle();
        n_checks++;
        if (AB_addr !== 8'd0 || i_lt_256 !== 1'b1 || sad !== 16'd105) begin
            n_fail++;
            $display("FAIL prio_clr_i got addr=%0d lt=%b sad=%0d want 0/1/105",
                     AB_addr, i_lt_256, sad);
        end
        sad_reg_ld = 1;
        step();
        idle();
        n_checks++;
        if (sad !== 16'd0) begin
            n_fail++;
            $display("FAIL prio_clr_sum got %0d want 0", sad);
        end
    endtask

    task automatic test_boundary();
        clear();
        i_inc = 1;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (k == 255) begin
                n_checks++;
                if (AB_addr !== 8'd255 || i_lt_256 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sat_255 got %0d/%b want 255/1", AB_addr, i_lt_256);
                end
            end
            if (k == 256 || k == 300) begin
                n_checks++;
                if (AB_addr !== 8'd0 || i_lt_256 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sat_%0d got %0d/%b want 0/0", k, AB_addr, i_lt_256);
                end
            end
        end
        idle();
        sum_clr8 = 1;
        step();
        sum_clr8 = 0;
        a8 = 8'hFF; b8 = 8'h00;
        sum_ld8 = 1;
        step();
        step();
        sum_ld8 = 0;
        sad_ld8 = 1;
        step();
        sad_ld8 = 0;
        n_checks++;
        if (sad8 !== 8'hFE || valid8 !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap8 got %0h/%b want fe/1", sad8, valid8);
        end
    endtask

    task automatic test_reset_midrun();
        fill_const(8'h00, 8'h00);
        for (int k = 0; k < 6; k++) a_mem[k] = 200;
        a_mem[6] = 34;
        run_block(16'd1234, "prior");
        fill_ramp();
        clear();
        accumulate(100);
        n_checks++;
        if (AB_addr !== 8'd100) begin
            n_fail++;
            $display("FAIL mid_i100 got %0d want 100", AB_addr);
        end
        AB_rd = 1; i_inc = 1; sum_ld = 1; sad_reg_ld = 1;
        rst = 1;
        step();
        rst = 0;
        idle();
        n_checks++;
        if (AB_addr !== 8'd0 || i_lt_256 !== 1'b1 || sad !== 16'd0 || sad_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset got addr=%0d lt=%b sad=%0d v=%b want 0/1/0/0",
                     AB_addr, i_lt_256, sad, sad_valid);
        end
        sad_reg_ld = 1;
        step();
        idle();
        n_checks++;
        if (sad !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_sum got %0d want 0", sad);
        end
        run_block(16'd32768, "after");
    endtask

    initial begin
        fill_const(8'h00, 8'h00);
        step();
        test_reset();
        test_full_block();
        test_extremes();
        test_priority();
        test_boundary();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sad_datapath.md
Name: sad_datapath

Overview:
- Datapath for the SAD (sum of absolute differences) engine, directly downstream of the SAD controller FSM.
- Consumes the controller's AB_rd, i_inc, i_clr, sum_ld, sum_clr and sad_reg_ld strobes and returns i_lt_256.
- Drives a shared address and read strobe to the A and B block memories (combinational-read), accumulates |A[i]-B[i]| over N elements, and holds the final result in sad_reg.

Parameters:
DATA_W, 8, width of each A/B memory word (unsigned)
N, 256, number of elements per block; must satisfy 1 <= N <= 2**ADDR_W
ADDR_W, 8, memory address width
SUM_W, 16, accumulator and result width; default holds 255*256 = 65280 without overflow

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
AB_rd  in  1  controller read strobe
i_inc  in  1  increment index counter
i_clr  in  1  clear index counter
sum_ld  in  1  accumulate |A-B| into sum
sum_clr  in  1  clear sum
sad_reg_ld  in  1  load sum into sad_reg
A_data  in  DATA_W  A memory read data, valid combinationally for current AB_addr
B_data  in  DATA_W  B memory read data, valid combinationally for current AB_addr
AB_addr  out  ADDR_W  shared A/B memory address = i[ADDR_W-1:0]
A_rd  out  1  A memory read enable = AB_rd
B_rd  out  1  B memory read enable = AB_rd
i_lt_256  out  1  status to controller: (i < N)
sad  out  SUM_W  registered result (sad_reg)
sad_valid  out  1  one-cycle pulse the cycle after sad_reg loads

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst; rst has priority over every strobe.
- State:
  - i: ADDR_W+1 bits, so it can represent N.
  - sum: SUM_W bits.
  - sad_reg: SUM_W bits.
  - sad_valid flop: 1 bit.
- Reset values: i=0, sum=0, sad_reg=0, sad_valid=0. Resulting outputs: AB_addr=0, i_lt_256=1, sad=0.
- Index counter:
  - i_clr -> i<=0.
  - Else i_inc -> i<=i+1.
  - i_clr wins if both are asserted.
  - i_inc while i==N: i holds at N (saturating; no wrap to 0).
- i_lt_256 is combinational from the i register: high iff i < N. It is valid in the same cycle i changes, so the controller's S2 decision sees the value updated by S3.
- AB_addr = i[ADDR_W-1:0] combinationally. A_rd and B_rd are combinational copies of AB_rd.
- Absolute difference:
  - diff = (A_data >= B_data) ? A_data-B_data : B_data-A_data.
  - Unsigned, DATA_W bits, combinational, zero-extended to SUM_W.
- Accumulator:
  - sum_clr -> sum<=0.
  - Else sum_ld -> sum<=sum+diff, modulo 2**SUM_W (wrap, no saturation, no flag).
  - sum_clr wins over sum_ld.
  - Accumulation depends only on sum_ld, not on AB_rd.
- Read timing: in the cycle the controller asserts AB_rd, sum_ld and i_inc together, diff is taken from the data at the current i. The same edge adds it to sum and advances i. Latency per element: 1 cycle.
- Result:
  - sad_reg_ld -> sad_reg<=sum. sad_reg otherwise holds, including across later sum_clr/i_clr.
  - If sad_reg_ld and sum_ld are asserted in the same cycle, sad_reg takes the pre-update sum.
- sad_valid <= sad_reg_ld: high exactly one cycle, coincident with the new sad value.
- Reset mid-run: the next edge forces all state to reset values; any partial sum is discarded and sad returns to 0.
- End-to-end run with the controller: go -> S1 (clear) -> N x (S2,S3) -> S2 -> S4. sad is valid 2N+3 cycles after the S1 cycle edge.

Test Plan:
1. Reset:
   - Stimulus: assert rst 1 cycle with random strobes/data.
   - Required: i=0, AB_addr=0, i_lt_256=1, sum=0, sad=0, sad_valid=0.
2. Full block, N=256:
   - Stimulus: A[k]=k, B[k]=255-k; drive clear, then 256 accumulate cycles, then sad_reg_ld.
   - Required: sad = sum of |2k-255| over k = 0..255 = 32768; sad_valid pulses once; i_lt_256 falls after the 256th i_inc.
3. Identical and extreme blocks:
   - Stimulus 1: A=B=0x5A for all k. Required: sad=0.
   - Stimulus 2: A=0xFF, B=0x00 for all k. Required: sad=65280, no wrap.
4. Priority:
   - Stimulus: same cycle i_clr+i_inc and sum_clr+sum_ld with sum=100, i=7.
   - Required: next i=0, sum=0.
   - Stimulus: sad_reg_ld+sum_ld same cycle. Required: sad equals the old sum.
5. Boundary:
   - Stimulus: i_inc held 300 cycles after clear.
   - Required: i saturates at 256; AB_addr=0 while i=256; i_lt_256=0.
   - Stimulus: SUM_W=8 instance, accumulate 0xFF twice. Required: sum=0xFE (wrap).
6. Reset mid-run:
   - Stimulus: assert rst at i=100, sum!=0, sad=1234 from a prior run.
   - Required: next cycle all state is 0.
   - Stimulus: a subsequent full run. Required: correct SAD.
